// File: rtl/ttt_game_controller.sv
// Two-player tic-tac-toe sequencer: owns the board, alternates turns, validates moves and
// ends the game on a win (reported back by winner_detector), a full board or a turn timeout.
module ttt_game_controller #(
  parameter logic [1:0]  START_PLAYER = 2'b01,
  parameter int unsigned TURN_TIMEOUT = 0,
  parameter int unsigned TIMER_W      = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       move_valid,
  input  logic [3:0] move_pos,
  input  logic       win,
  input  logic [1:0] who,
  output logic [1:0] pos1,
  output logic [1:0] pos2,
  output logic [1:0] pos3,
  output logic [1:0] pos4,
  output logic [1:0] pos5,
  output logic [1:0] pos6,
  output logic [1:0] pos7,
  output logic [1:0] pos8,
  output logic [1:0] pos9,
  output logic [1:0] turn,
  output logic       move_ack,
  output logic       move_err,
  output logic       game_over,
  output logic [1:0] result,
  output logic       forfeit,
  output logic [3:0] move_count
);

  typedef enum logic [1:0] {S_IDLE, S_TURN, S_EVAL, S_OVER} state_t;

  localparam bit                 TIMEOUT_EN = (TURN_TIMEOUT != 0);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TURN_TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [8:0][1:0]     board_q, board_d;
  logic [1:0]          turn_q, turn_d;
  logic [1:0]          result_q, result_d;
  logic [3:0]          count_q, count_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic                over_q, over_d;
  logic                forfeit_q, forfeit_d;
  logic                cell_free;
  logic                legal;

  function automatic logic [1:0] other_player(input logic [1:0] p);
    return (p == 2'b01) ? 2'b10 : 2'b01;
  endfunction

  // Positions 0 and 10..15 match no cell, so they are never free.
  always_comb begin
    cell_free = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (move_pos == 4'(i + 1) && board_q[i] == 2'b00) cell_free = 1'b1;
    end
  end

  assign legal = move_valid && cell_free;

  always_comb begin
    state_d   = state_q;
    board_d   = board_q;
    turn_d    = turn_q;
    result_d  = result_q;
    count_d   = count_q;
    timer_d   = timer_q;
    over_d    = over_q;
    forfeit_d = forfeit_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;

    if (start) begin
      state_d   = S_TURN;
      board_d   = '0;
      turn_d    = START_PLAYER;
      result_d  = 2'b00;
      count_d   = 4'd0;
      timer_d   = '0;
      over_d    = 1'b0;
      forfeit_d = 1'b0;
    end else begin
      case (state_q)
        S_TURN: begin
          if (legal) begin
            for (int i = 0; i < 9; i++) begin
              if (move_pos == 4'(i + 1)) board_d[i] = turn_q;
            end
            count_d = count_q + 4'd1;
            ack_d   = 1'b1;
            state_d = S_EVAL;
          end else begin
            err_d = move_valid;
            // A rejected move does not restart the clock on the current player.
            if (TIMEOUT_EN && timer_q == TIMER_LAST) begin
              state_d   = S_OVER;
              over_d    = 1'b1;
              forfeit_d = 1'b1;
              result_d  = other_player(turn_q);
              turn_d    = 2'b00;
            end else if (TIMEOUT_EN) begin
              timer_d = timer_q + TIMER_W'(1);
            end
          end
        end
        S_EVAL: begin
          if (win) begin
            state_d  = S_OVER;
            over_d   = 1'b1;
            result_d = who;
            turn_d   = 2'b00;
          end else if (count_q == 4'd9) begin
            state_d  = S_OVER;
            over_d   = 1'b1;
            result_d = 2'b11;
            turn_d   = 2'b00;
          end else begin
            state_d = S_TURN;
            turn_d  = other_player(turn_q);
            timer_d = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      board_q   <= '0;
      turn_q    <= 2'b00;
      result_q  <= 2'b00;
      count_q   <= 4'd0;
      timer_q   <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      over_q    <= 1'b0;
      forfeit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      board_q   <= board_d;
      turn_q    <= turn_d;
      result_q  <= result_d;
      count_q   <= count_d;
      timer_q   <= timer_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      over_q    <= over_d;
      forfeit_q <= forfeit_d;
    end
  end

  assign pos1       = board_q[0];
  assign pos2       = board_q[1];
  assign pos3       = board_q[2];
  assign pos4       = board_q[3];
  assign pos5       = board_q[4];
  assign pos6       = board_q[5];
  assign pos7       = board_q[6];
  assign pos8       = board_q[7];
  assign pos9       = board_q[8];
  assign turn       = turn_q;
  assign move_ack   = ack_q;
  assign move_err   = err_q;
  assign game_over  = over_q;
  assign result     = result_q;
  assign forfeit    = forfeit_q;
  assign move_count = count_q;

endmodule

// File: tb/tb_ttt_game_controller.sv
// Bench for ttt_game_controller: a table of per-cycle vectors feeding a scoreboard queue,
// a behavioural winner_detector, and hand-written timeout / start-priority sequences.
module tb_ttt_game_controller;

  localparam logic [1:0] N = 2'b00, X = 2'b01, O = 2'b10, D = 2'b11;
  localparam string E = ".........";

  logic       clk = 1'b0;
  logic       reset = 1'b1, start = 1'b0, move_valid = 1'b0;
  logic [3:0] move_pos = 4'd0;
  logic       win;
  logic [1:0] who;
  logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
  logic [1:0] turn, result;
  logic       move_ack, move_err, game_over, forfeit;
  logic [3:0] move_count;

  always #5 clk = ~clk;

  ttt_game_controller #(.START_PLAYER(2'b01), .TURN_TIMEOUT(8), .TIMER_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .move_valid(move_valid), .move_pos(move_pos),
    .win(win), .who(who),
    .pos1(pos1), .pos2(pos2), .pos3(pos3), .pos4(pos4), .pos5(pos5),
    .pos6(pos6), .pos7(pos7), .pos8(pos8), .pos9(pos9),
    .turn(turn), .move_ack(move_ack), .move_err(move_err), .game_over(game_over),
    .result(result), .forfeit(forfeit), .move_count(move_count)
  );

  // Stand-in for winner_detector: combinational three-in-a-row check.
  function automatic logic [1:0] line3(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
    return (a != 2'b00 && a == b && b == c) ? a : 2'b00;
  endfunction

  logic [1:0] line_win;
  always_comb begin
    line_win = line3(pos1, pos2, pos3) | line3(pos4, pos5, pos6) | line3(pos7, pos8, pos9)
             | line3(pos1, pos4, pos7) | line3(pos2, pos5, pos8) | line3(pos3, pos6, pos9)
             | line3(pos1, pos5, pos9) | line3(pos3, pos5, pos7);
    win = (line_win != 2'b00);
    who = line_win;
  end

  typedef struct packed {
    logic        ack;
    logic        err;
    logic        over;
    logic        forf;
    logic [1:0]  res;
    logic [1:0]  trn;
    logic [3:0]  cnt;
    logic [17:0] brd;
  } out_t;

  typedef struct {
    logic       rst;
    logic       st;
    logic       mv;
    logic [3:0] pos;
    out_t       exp;
  } vec_t;

  vec_t tbl[$];
  out_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [17:0] b9(input string s);
    logic [17:0] b;
    b = '0;
    for (int i = 0; i < 9; i++) begin
      b = b << 2;
      if (s[i] == "X") b[1:0] = 2'b01;
      else if (s[i] == "O") b[1:0] = 2'b10;
    end
    return b;
  endfunction

  function automatic out_t mk(input logic ack, input logic err, input logic over, input logic forf,
                              input logic [1:0] res, input logic [1:0] trn, input logic [3:0] cnt,
                              input string b);
    out_t o;
    o.ack = ack; o.err = err; o.over = over; o.forf = forf;
    o.res = res; o.trn = trn; o.cnt = cnt; o.brd = b9(b);
    return o;
  endfunction

  function automatic out_t sample();
    out_t o;
    o.ack = move_ack; o.err = move_err; o.over = game_over; o.forf = forfeit;
    o.res = result; o.trn = turn; o.cnt = move_count;
    o.brd = {pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9};
    return o;
  endfunction

  function automatic string fmt(input out_t o);
    return $sformatf("ack=%b err=%b over=%b forf=%b res=%b turn=%b cnt=%0d board=%05h",
                     o.ack, o.err, o.over, o.forf, o.res, o.trn, o.cnt, o.brd);
  endfunction

  task automatic check(input string name, input out_t exp);
    out_t got;
    got = sample();
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %s, required %s", name, fmt(got), fmt(exp));
    end
  endtask

  task automatic add(input logic rst, input logic st, input logic mv, input logic [3:0] pos,
                     input logic ack, input logic err, input logic over, input logic forf,
                     input logic [1:0] res, input logic [1:0] trn, input logic [3:0] cnt,
                     input string b);
    vec_t v;
    v.rst = rst; v.st = st; v.mv = mv; v.pos = pos;
    v.exp = mk(ack, err, over, forf, res, trn, cnt, b);
    tbl.push_back(v);
  endtask

  // A legal move by player p followed by the evaluation cycle that hands over to nxt.
  task automatic move2(input logic [3:0] pos, input logic [1:0] p, input logic [3:0] cnt,
                       input string b, input logic [1:0] nxt);
    add(0, 0, 1, pos, 1, 0, 0, 0, N, p,   cnt, b);
    add(0, 0, 0, 0,   0, 0, 0, 0, N, nxt, cnt, b);
  endtask

  initial begin
    int cyc;

    // Reset, and a move request while idle.
    add(1, 0, 0, 0, 0, 0, 0, 0, N, N, 0, E);
    add(0, 0, 1, 1, 0, 0, 0, 0, N, N, 0, E);
    // X wins along the top row.
    add(0, 1, 0, 0, 0, 0, 0, 0, N, X, 0, E);
    move2(1, X, 1, "X........", O);
    move2(4, O, 2, "X..O.....", X);
    move2(2, X, 3, "XX.O.....", O);
    move2(5, O, 4, "XX.OO....", X);
    add(0, 0, 1, 3, 1, 0, 0, 0, N, X, 5, "XXXOO....");
    add(0, 0, 0, 0, 0, 0, 1, 0, X, N, 5, "XXXOO....");
    // Moves to an empty cell in OVER are ignored.
    for (int i = 0; i < 3; i++) add(0, 0, 1, 6, 0, 0, 1, 0, X, N, 5, "XXXOO....");
    // Illegal moves: occupied, 0, 10; then a legal one.
    add(0, 1, 0, 0, 0, 0, 0, 0, N, X, 0, E);
    move2(1, X, 1, "X........", O);
    add(0, 0, 1, 1,  0, 1, 0, 0, N, O, 1, "X........");
    add(0, 0, 1, 0,  0, 1, 0, 0, N, O, 1, "X........");
    add(0, 0, 1, 10, 0, 1, 0, 0, N, O, 1, "X........");
    move2(5, O, 2, "X...O....", X);
    move2(2, X, 3, "XX..O....", O);
    // start wins over a simultaneous move.
    add(0, 1, 1, 3, 0, 0, 0, 0, N, X, 0, E);
    move2(9, X, 1, "........X", O);
    // reset wins over a simultaneous move; IDLE then ignores moves.
    add(1, 0, 1, 1, 0, 0, 0, 0, N, N, 0, E);
    add(0, 0, 1, 1, 0, 0, 0, 0, N, N, 0, E);
    // Draw: 1,2,3,5,4,6,8,7,9.
    add(0, 1, 0, 0, 0, 0, 0, 0, N, X, 0, E);
    move2(1, X, 1, "X........", O);
    move2(2, O, 2, "XO.......", X);
    move2(3, X, 3, "XOX......", O);
    move2(5, O, 4, "XOX.O....", X);
    move2(4, X, 5, "XOXXO....", O);
    move2(6, O, 6, "XOXXOO...", X);
    move2(8, X, 7, "XOXXOO.X.", O);
    move2(7, O, 8, "XOXXOOOX.", X);
    add(0, 0, 1, 9, 1, 0, 0, 0, N, X, 9, "XOXXOOOXX");
    add(0, 0, 0, 0, 0, 0, 1, 0, D, N, 9, "XOXXOOOXX");
    // Timeout forfeit; an illegal move on the third cycle does not restart the timer.
    add(0, 1, 0, 0, 0, 0, 0, 0, N, X, 0, E);
    for (int i = 0; i < 7; i++) add(0, 0, (i == 2), 0, 0, (i == 2), 0, 0, N, X, 0, E);
    add(0, 0, 0, 0, 0, 0, 1, 1, O, N, 0, E);
    // A legal move on the final cycle beats the timeout.
    add(0, 1, 0, 0, 0, 0, 0, 0, N, X, 0, E);
    for (int i = 0; i < 7; i++) add(0, 0, 0, 0, 0, 0, 0, 0, N, X, 0, E);
    move2(5, X, 1, "....X....", O);
    add(0, 0, 0, 0, 0, 0, 0, 0, N, O, 1, "....X....");

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      reset      = tbl[i].rst;
      start      = tbl[i].st;
      move_valid = tbl[i].mv;
      move_pos   = tbl[i].pos;
      sb.push_back(tbl[i].exp);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), sb.pop_front());
      n_cmp++;
      if (move_ack && move_err) begin
        n_bad++;
        $display("FAIL ack_err_excl vec%0d: got ack=%b err=%b, required not both 1", i, move_ack, move_err);
      end
    end

    // Measure timeout latency from the edge that enters TURN.
    @(negedge clk);
    reset = 1'b0; start = 1'b1; move_valid = 1'b0; move_pos = 4'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    while (!game_over && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    n_cmp++;
    if (cyc != 8 || forfeit !== 1'b1 || result !== O) begin
      n_bad++;
      $display("FAIL timeout_latency: got cycles=%0d forfeit=%b result=%b, required cycles=8 forfeit=1 result=10",
               cyc, forfeit, result);
    end

    // From OVER, start together with a move: new game, move dropped; then the move is taken.
    @(negedge clk);
    start = 1'b1; move_valid = 1'b1; move_pos = 4'd1;
    sb.push_back(mk(0, 0, 0, 0, N, X, 0, E));
    @(posedge clk);
    #1;
    check("restart_drops_move", sb.pop_front());
    start = 1'b0;
    sb.push_back(mk(1, 0, 0, 0, N, X, 1, "X........"));
    @(posedge clk);
    #1;
    check("first_move_after_restart", sb.pop_front());
    move_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within 100000 time units");
    $fatal(1);
  end

endmodule

// File: doc/ttt_game_controller.md
Name: ttt_game_controller

Overview:
Sequences a two-player tic-tac-toe game. It owns the 9-cell board register, alternates turns and validates each move request. It feeds the board to the existing winner_detector and takes that block's win/who outputs back to end the game. It also detects a draw (board full) and an optional per-turn timeout forfeit.

Parameters:
START_PLAYER, 2'b01, code of the player who moves first (2'b01 = X, 2'b10 = O).
TURN_TIMEOUT, 0, cycles allowed per turn before forfeit; 0 disables the timeout.
TIMER_W, 16, width of the turn timer; TURN_TIMEOUT must fit in TIMER_W bits.

Ports:
clk  in  1  single clock, rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  start or restart a game (level is sampled every cycle).
move_valid  in  1  move request strobe for the player whose turn it is.
move_pos  in  4  target cell, 1..9 (row-major, 1 = top-left).
win  in  1  from winner_detector, driven combinationally from pos1..pos9.
who  in  2  from winner_detector; cell code of the winner.
pos1..pos9  out  2 each  board cells: 00 empty, 01 X, 10 O.
turn  out  2  player to move: 01, 10, or 00 when no game is in progress.
move_ack  out  1  one-cycle pulse; the move was accepted.
move_err  out  1  one-cycle pulse; the move was rejected.
game_over  out  1  level; the game has ended.
result  out  2  00 none, 01 X won, 10 O won, 11 draw.
forfeit  out  1  level; the game ended by timeout.
move_count  out  4  number of accepted moves, 0..9.

Behaviour:
- Reset has priority over everything. On reset: state IDLE; pos1..9, turn, result, move_count and the timer are 0; move_ack, move_err, game_over and forfeit are 0.
- States:
  - IDLE: waits for start.
  - TURN: waits for a move.
  - EVAL: one cycle; evaluates the updated board.
  - OVER: game ended; holds everything.
- start, in any state: next edge clears the board, move_count, result, game_over, forfeit and the timer, sets turn = START_PLAYER, and enters TURN.
  - start beats move_valid in the same cycle; that move is dropped with no ack and no err.
- TURN with move_valid = 1:
  - Legal means move_pos is in 1..9 and the addressed cell is 00.
  - Legal move, at the next edge:
    - the cell gets the turn code;
    - move_count increments;
    - move_ack is 1 for one cycle;
    - state goes to EVAL.
  - Illegal move (pos 0, pos 10..15, or an occupied cell):
    - move_err is 1 for one cycle at the next edge;
    - board and turn are unchanged;
    - the timer is not reset; state stays TURN.
- EVAL, evaluated in priority order:
  - win = 1: go to OVER with result = who.
  - else move_count == 9: go to OVER with result = 11.
  - else: toggle turn (01 <-> 10), clear the timer, return to TURN.
- Latency: a legal move sampled at edge k gives the updated cell and move_ack in cycle k+1. Either turn toggles or game_over/result are set at edge k+2.
- Timeout (TURN_TIMEOUT > 0):
  - The timer counts cycles spent in TURN.
  - If the timer == TURN_TIMEOUT-1 and no legal move is present that cycle, the next edge goes to OVER with:
    - forfeit = 1;
    - result = the opponent's code;
    - game_over = 1.
  - A legal move on the final cycle is accepted (the move wins over the timeout).
- OVER:
  - game_over = 1 and turn = 00.
  - Board, result and forfeit hold.
  - move_valid is ignored (no ack, no err) until start or reset.
- In IDLE and EVAL, move_valid is ignored with no ack and no err.
- move_ack and move_err are never high together. Both are registered outputs.

Test Plan:
1. Reset, then start. Moves X1, O4, X2, O5, X3 -> after the 5th ack: pos1..3 = 01, pos4..5 = 10, game_over = 1, result = 01, move_count = 5, forfeit = 0, turn = 00.
2. After X1, O requests move_pos = 1, then 0, then 10 -> three move_err pulses, pos1 stays 01, turn stays 10, move_count = 1. O then plays 5 -> move_ack.
3. Draw sequence 1,2,3,5,4,6,8,7,9 (alternating, X first) -> after the 9th move: game_over = 1, result = 11, move_count = 9, all cells non-zero.
4. TURN_TIMEOUT = 8: start, then no moves -> game_over = 1 exactly 8 cycles after entering TURN, forfeit = 1, result = 10. A rerun with a legal X move on the 8th cycle -> move accepted, no forfeit.
5. Mid-game (3 moves in), assert start together with move_valid -> board all 00, move_count = 0, turn = START_PLAYER, no ack/err. Repeat with reset -> all outputs at reset values, state IDLE (turn = 00).
6. In OVER, drive move_valid to an empty cell for 3 cycles -> no ack, no err, board unchanged; start -> new game begins in TURN.
